// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory load/store over a req/ack bus, thread start/stop pulses,
// and the MEM/WB register. Stalls the pipeline while its own access is outstanding.
module mem_stage #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ins_mem,
    input  logic [31:0] pc_mem,
    input  logic [31:0] addr_mem,
    input  logic [31:0] exe_data_mem,
    input  logic [2:0]  trd_mem,
    input  logic [4:0]  reg_wr_mem,
    input  logic        wr_en_mem,
    input  logic        wb_sel_mem,
    input  logic [1:0]  mem_ctrl_mem,
    input  logic [1:0]  trd_ctrl_mem,
    input  logic [2:0]  obj_trd_mem,
    input  logic        stall_ext,
    input  logic        flushMEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_mem,
    output logic [31:0] ins_wb,
    output logic [31:0] pc_wb,
    output logic [2:0]  trd_wb,
    output logic [4:0]  reg_wr_wb,
    output logic [31:0] wb_data_wb,
    output logic        wr_en_wb,
    output logic        trd_start_wb,
    output logic        trd_stop_wb,
    output logic [2:0]  trd_obj_wb,
    output logic        mem_err
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;
    state_t r_state, w_state_nxt;

    logic [CW-1:0] r_cnt;
    logic          r_kill, r_done, r_done_err, r_req, r_we, r_mem_err;
    logic [31:0]   r_addr, r_wdata, r_rdata;
    logic [31:0]   r_ins_wb, r_pc_wb, r_wb_data_wb;
    logic [2:0]    r_trd_wb, r_trd_obj_wb;
    logic [4:0]    r_reg_wr_wb;
    logic          r_wr_en_wb, r_trd_start_wb, r_trd_stop_wb;

    logic w_acc, w_mis, w_busy, w_ack, w_timeout, w_own_end, w_start, w_adv, w_bubble;
    logic [31:0] w_load_data;

    assign w_acc     = (mem_ctrl_mem == 2'b01) || (mem_ctrl_mem == 2'b10);
    assign w_mis     = w_acc && (addr_mem[1:0] != 2'b00);
    assign w_busy    = (r_state == S_BUSY);
    assign w_ack     = w_busy && dmem_ack;
    assign w_timeout = w_busy && !dmem_ack && (r_cnt == CNT_LAST);
    // An access finishing after a flush belongs to no instruction in MEM.
    assign w_own_end = (w_ack || w_timeout) && !r_kill;
    // r_done marks that the instruction held in MEM already finished its access.
    assign w_start   = !w_busy && w_acc && !w_mis && !stall_ext && !flushMEM && !r_done;
    assign stall_mem = w_acc && !w_mis && !flushMEM && !r_done && !w_own_end;
    assign w_adv     = !stall_ext && !stall_mem;
    assign w_bubble  = flushMEM || (w_adv && w_mis) || w_timeout || (w_ack && r_kill)
                       || (w_adv && r_done && r_done_err);
    assign w_load_data = r_done ? r_rdata : dmem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
            S_BUSY:  if (dmem_ack || w_timeout) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_kill  <= 1'b0;
        end else if (w_start) begin
            r_req   <= 1'b1;
            r_we    <= (mem_ctrl_mem == 2'b10);
            r_addr  <= {addr_mem[31:2], 2'b00};
            r_wdata <= exe_data_mem;
            r_cnt   <= '0;
            r_kill  <= 1'b0;
        end else if (w_busy) begin
            if (dmem_ack || w_timeout) r_req <= 1'b0;
            else                       r_cnt <= r_cnt + 1'b1;
            if (flushMEM) r_kill <= 1'b1;
        end
    end

    // Completion seen while stall_ext holds MEM is remembered so the access is not reissued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done     <= 1'b0;
            r_done_err <= 1'b0;
            r_rdata    <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_mem_err <= (w_adv && w_mis && !flushMEM) || w_timeout;
            if (flushMEM || w_adv) begin
                r_done <= 1'b0;
            end else if (w_own_end) begin
                r_done     <= 1'b1;
                r_done_err <= w_timeout;
                r_rdata    <= dmem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ins_wb <= '0; r_pc_wb <= '0; r_trd_wb <= '0; r_reg_wr_wb <= '0;
            r_wb_data_wb <= '0; r_wr_en_wb <= 1'b0; r_trd_obj_wb <= '0;
            r_trd_start_wb <= 1'b0; r_trd_stop_wb <= 1'b0;
        end else if (w_bubble || stall_mem) begin
            r_ins_wb <= '0; r_pc_wb <= '0; r_trd_wb <= '0; r_reg_wr_wb <= '0;
            r_wb_data_wb <= '0; r_wr_en_wb <= 1'b0; r_trd_obj_wb <= '0;
            r_trd_start_wb <= 1'b0; r_trd_stop_wb <= 1'b0;
        end else if (!stall_ext) begin
            r_ins_wb       <= ins_mem;
            r_pc_wb        <= pc_mem;
            r_trd_wb       <= trd_mem;
            r_reg_wr_wb    <= reg_wr_mem;
            r_wr_en_wb     <= wr_en_mem;
            r_wb_data_wb   <= (wb_sel_mem && mem_ctrl_mem == 2'b01) ? w_load_data : exe_data_mem;
            r_trd_obj_wb   <= obj_trd_mem;
            r_trd_start_wb <= (trd_ctrl_mem == 2'b01);
            r_trd_stop_wb  <= (trd_ctrl_mem == 2'b10);
        end else begin
            r_trd_start_wb <= 1'b0;
            r_trd_stop_wb  <= 1'b0;
        end
    end

    assign dmem_req     = r_req;
    assign dmem_we      = r_we;
    assign dmem_addr    = r_addr;
    assign dmem_wdata   = r_wdata;
    assign ins_wb       = r_ins_wb;
    assign pc_wb        = r_pc_wb;
    assign trd_wb       = r_trd_wb;
    assign reg_wr_wb    = r_reg_wr_wb;
    assign wb_data_wb   = r_wb_data_wb;
    assign wr_en_wb     = r_wr_en_wb;
    assign trd_start_wb = r_trd_start_wb;
    assign trd_stop_wb  = r_trd_stop_wb;
    assign trd_obj_wb   = r_trd_obj_wb;
    assign mem_err      = r_mem_err;
endmodule
